// File: rtl/aes_pkg.sv
// Shared Rijndael helpers: byte width, legal block widths and the
// ShiftRows column mapping used by the forward and inverse datapaths.
package aes_pkg;

  localparam int BYTE = 8;
  localparam int ROWS = 4;

  // Rijndael defines ShiftRows only for 4, 6 or 8 state columns
  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // The 256-bit state skips offset 2 so rows 2 and 3 rotate by 3 and 4
  function automatic int row_offset(input int nb, input int r);
    if ((nb == 8) && (r >= 2)) begin
      return r + 1;
    end
    return r;
  endfunction

  // Column of the input byte that lands in output (r, c)
  function automatic int src_col(input int nb, input int r, input int c, input bit inv);
    int off;
    off = row_offset(nb, r);
    if (inv) begin
      return (c - off + nb) % nb;
    end
    return (c + off) % nb;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation. Both mappings are
// fixed wiring; inv only selects which wire feeds each output byte.
module shift_rows_perm
  import aes_pkg::src_col;
#(
  parameter int BYTE = 8,
  parameter int NB   = 4
) (
  input  logic [4*NB*BYTE-1:0] state,
  input  logic                 inv,
  output logic [4*NB*BYTE-1:0] permuted
);

  localparam int W = 4 * NB * BYTE;

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int K  = 4 * c + r;
      localparam int KF = 4 * src_col(NB, r, c, 1'b0) + r;
      localparam int KI = 4 * src_col(NB, r, c, 1'b1) + r;
      assign permuted[W-1-BYTE*K -: BYTE] =
        inv ? state[W-1-BYTE*KI -: BYTE] : state[W-1-BYTE*KF -: BYTE];
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// Two-stage ShiftRows / InvShiftRows pipeline with valid/ready handshake.
// S1 captures the incoming state, the permutation sits between S1 and S2,
// and S2 presents the result. Define SHIFT_ROWS_PARITY_EN to add out_par,
// the per-byte even parity of out_data registered alongside it.
module shift_rows_pipe
  import aes_pkg::nb_legal;
#(
  parameter int BYTE     = 8,
  parameter int NB       = 4,
  parameter int SENTENCE = 32 * NB
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SENTENCE-1:0] in_data,
  input  logic                in_inv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SENTENCE-1:0] out_data,
  output logic                out_inv
`ifdef SHIFT_ROWS_PARITY_EN
  ,
  output logic [SENTENCE/8-1:0] out_par
`endif
);

  if (!nb_legal(NB) || (SENTENCE != 4 * NB * BYTE)) begin : g_bad_cfg
    $error("shift_rows_pipe: NB must be 4, 6 or 8 and SENTENCE must equal 32*NB");
  end

  logic                s1_valid;
  logic [SENTENCE-1:0] s1_data;
  logic                s1_inv;
  logic [SENTENCE-1:0] perm_data;
  logic                s2_load;
  logic                s1_load;

  // S2 takes S1 whenever it is empty or being drained; S1 refills on that same edge
  always_comb begin
    s2_load  = s1_valid && (!out_valid || out_ready);
    in_ready = !s1_valid || s2_load;
    s1_load  = in_valid && in_ready;
  end

  shift_rows_perm #(
    .BYTE (BYTE),
    .NB   (NB)
  ) u_perm (
    .state    (s1_data),
    .inv      (s1_inv),
    .permuted (perm_data)
  );

  // S1 register: capture on handshake, empty once its content moves to S2
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_inv   <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_data  <= in_data;
        s1_inv   <= in_inv;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // S2 register: hold the permuted state until downstream accepts it
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_inv   <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        out_data  <= perm_data;
        out_inv   <= s1_inv;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SHIFT_ROWS_PARITY_EN
  logic [SENTENCE/8-1:0] par_next;

  // Even parity per byte of the permuted state, byte 0 in the top bit
  always_comb begin
    par_next = '0;
    for (int k = 0; k < SENTENCE / 8; k++) begin
      par_next[SENTENCE/8-1-k] = ^perm_data[SENTENCE-1-8*k -: 8];
    end
  end

  // Parity travels with the data so it stays matched under stall
  always_ff @(posedge clk) begin
    if (rst) begin
      out_par <= '0;
    end else if (s2_load) begin
      out_par <= par_next;
    end
  end
`else
  // Parity disabled: no extra state beside the data path
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench for shift_rows_pipe: an NB=4 instance checked through
// a scoreboard plus directed probes, and an NB=8 instance checked directly.
// Define SHIFT_ROWS_PARITY_EN to also exercise out_par.
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic         in_valid, in_ready, in_inv, out_valid, out_ready, out_inv;
  logic [127:0] in_data, out_data;
`ifdef SHIFT_ROWS_PARITY_EN
  logic [15:0]  out_par;
`endif

  logic         in_valid8, in_ready8, in_inv8, out_valid8, out_ready8, out_inv8;
  logic [255:0] in_data8, out_data8;
`ifdef SHIFT_ROWS_PARITY_EN
  logic [31:0]  out_par8;
`endif

  shift_rows_pipe #(.NB(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_inv   (out_inv)
`ifdef SHIFT_ROWS_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  shift_rows_pipe #(.NB(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_data   (in_data8),
    .in_inv    (in_inv8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_data  (out_data8),
    .out_inv   (out_inv8)
`ifdef SHIFT_ROWS_PARITY_EN
    ,
    .out_par   (out_par8)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  logic [128:0] exp_q[$];
  logic [128:0] sb_e;

  function automatic logic [255:0] model(input logic [255:0] d, input int nb, input logic inv);
    int offs[4];
    int w;
    int src;
    logic [255:0] res;
    if (nb == 8) offs = '{0, 1, 3, 4};
    else         offs = '{0, 1, 2, 3};
    w   = 32 * nb;
    res = '0;
    for (int c = 0; c < nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - offs[r] + nb) % nb : (c + offs[r]) % nb;
        res[w-1-8*(4*c+r) -: 8] = d[w-1-8*(4*src+r) -: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] d, input logic inv, input logic [127:0] expd);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    assert (in_ready === 1'b1)
    else begin
      failures++;
      $error("[TB] FAIL accept_timeout observed=%b expected=1", in_ready);
    end
    if (in_ready === 1'b1) exp_q.push_back({inv, expd});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: each output accepted on the coming edge must match the oldest pending input
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() > 0)
      else begin
        failures++;
        $error("[TB] FAIL sb_unexpected observed=%h expected=none", out_data);
      end
      if (exp_q.size() > 0) begin
        sb_e = exp_q.pop_front();
        checkOutput("sb_data", 256'(out_data), 256'(sb_e[127:0]));
        checkOutput("sb_inv", 256'(out_inv), 256'(sb_e[128]));
      end
      pops++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [127:0] fips_in  = 128'hd42711aee0bf98f1b8b45de51e415230;
  logic [127:0] fips_out = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  logic [127:0] seq      = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] img      = 128'h00050a0f04090e03080d02070c01060b;
  logic [255:0] in8, fwd8;
  logic [127:0] bp_d, held, ra, rb;
  logic         bp_inv, held_inv, took;
  int           bp_acc, pops_before;

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_inv     = 1'b0;
    out_ready  = 1'b1;
    in_valid8  = 1'b0;
    in_data8   = '0;
    in_inv8    = 1'b0;
    out_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_out_valid", 256'(out_valid), 256'(0));
    checkOutput("rst_out_data", 256'(out_data), 256'(0));
    checkOutput("rst_out_inv", 256'(out_inv), 256'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_in_ready", 256'(in_ready), 256'(1));

    $display("[TB] FIPS-197 forward vector and latency");
    applyStimulus(fips_in, 1'b0, fips_out);
    in_valid = 1'b0;
    checkOutput("lat_edge1_valid", 256'(out_valid), 256'(0));
    @(posedge clk);
    #1;
    checkOutput("lat_edge2_valid", 256'(out_valid), 256'(1));
    checkOutput("fips_data", 256'(out_data), 256'(fips_out));
    checkOutput("fips_inv", 256'(out_inv), 256'(0));
    idle(3);

    $display("[TB] alternating directions back to back");
    pops_before = pops;
    applyStimulus(seq, 1'b0, img);
    applyStimulus(img, 1'b1, seq);
    applyStimulus(seq, 1'b0, img);
    applyStimulus(img, 1'b1, seq);
    in_valid = 1'b0;
    checkOutput("alt_valid_a", 256'(out_valid), 256'(1));
    @(posedge clk);
    #1;
    checkOutput("alt_valid_b", 256'(out_valid), 256'(1));
    checkOutput("alt_last_data", 256'(out_data), 256'(seq));
    checkOutput("alt_last_inv", 256'(out_inv), 256'(1));
    @(posedge clk);
    #1;
    checkOutput("alt_drained", 256'(out_valid), 256'(0));
    checkOutput("alt_one_per_cycle", 256'(pops - pops_before), 256'(4));

    $display("[TB] NB=8 forward and inverse");
    for (int k = 0; k < 32; k++) in8[255-8*k -: 8] = 8'(k);
    in_valid8 = 1'b1;
    in_data8  = in8;
    in_inv8   = 1'b0;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("nb8_valid", 256'(out_valid8), 256'(1));
    checkOutput("nb8_col0", 256'(out_data8[255 -: 32]), 256'(32'h00050e13));
    checkOutput("nb8_col7", 256'(out_data8[31:0]), 256'(32'h1c010a0f));
    checkOutput("nb8_fwd_full", out_data8, model(in8, 8, 1'b0));
    fwd8      = out_data8;
    in_valid8 = 1'b1;
    in_data8  = fwd8;
    in_inv8   = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("nb8_inv_data", out_data8, in8);
    checkOutput("nb8_inv_tag", 256'(out_inv8), 256'(1));

    $display("[TB] backpressure with continuous input");
    out_ready = 1'b0;
    bp_acc    = 0;
    bp_d      = rand128();
    bp_inv    = 1'b0;
    held      = '0;
    held_inv  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = bp_d;
      in_inv   = bp_inv;
      @(negedge clk);
      took = in_ready;
      if (took) exp_q.push_back({bp_inv, model(256'(bp_d), 4, bp_inv)[127:0]});
      @(posedge clk);
      #1;
      if (took) begin
        bp_acc++;
        bp_d   = rand128();
        bp_inv = ~bp_inv;
      end
      if (i == 1) begin
        held     = out_data;
        held_inv = out_inv;
      end
      if (i >= 2) begin
        checkOutput("stall_data", 256'(out_data), 256'(held));
        checkOutput("stall_inv", 256'(out_inv), 256'(held_inv));
      end
    end
    checkOutput("stall_accepts", 256'(bp_acc), 256'(2));
    checkOutput("stall_in_ready", 256'(in_ready), 256'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(bp_d, bp_inv, model(256'(bp_d), 4, bp_inv)[127:0]);
      bp_d   = rand128();
      bp_inv = ~bp_inv;
    end
    idle(5);
    checkOutput("bp_all_emerged", 256'(exp_q.size()), 256'(0));

    $display("[TB] reset with both stages full");
    out_ready = 1'b0;
    ra = rand128();
    rb = rand128();
    applyStimulus(ra, 1'b0, model(256'(ra), 4, 1'b0)[127:0]);
    applyStimulus(rb, 1'b1, model(256'(rb), 4, 1'b1)[127:0]);
    in_valid = 1'b0;
    checkOutput("full_before_rst", 256'(out_valid), 256'(1));
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    checkOutput("midrst_out_valid", 256'(out_valid), 256'(0));
    checkOutput("midrst_out_data", 256'(out_data), 256'(0));
    checkOutput("midrst_out_inv", 256'(out_inv), 256'(0));
    checkOutput("midrst_in_ready", 256'(in_ready), 256'(1));
    rst       = 1'b0;
    out_ready = 1'b1;
    idle(4);
    checkOutput("no_stale_output", 256'(out_valid), 256'(0));

`ifdef SHIFT_ROWS_PARITY_EN
    $display("[TB] per-byte parity");
    applyStimulus({16{8'h01}}, 1'b0, {16{8'h01}});
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("par_ones", 256'(out_par), 256'(16'hffff));
    applyStimulus({16{8'h03}}, 1'b1, {16{8'h03}});
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("par_zeros", 256'(out_par), 256'(16'h0000));
    idle(3);
`endif

    idle(5);
    checkOutput("sb_empty", 256'(exp_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
Pipelined, parametrised Rijndael ShiftRows / InvShiftRows stage with valid/ready handshake. Supports block widths Nb = 4, 6 or 8 columns (128/192/256-bit state). Direction is selected per transfer. Sits between SubBytes and MixColumns in the round datapath, and is reused by the decrypt path in inverse mode.

Parameters:
BYTE, 8, bits per state byte
NB, 4, state columns; legal values 4, 6, 8; any other value is an elaboration error
SENTENCE, 32*NB, state width in bits (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  input transfer request
in_ready  out  1  stage can accept input
in_data  in  SENTENCE  state; byte k = in_data[SENTENCE-1-8k -: 8], state(r,c) = byte 4c+r
in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows
out_valid  out  1  result available
out_ready  in  1  downstream accepts
out_data  out  SENTENCE  permuted state, same byte layout
out_inv  out  1  in_inv echoed alongside its data

Behaviour:
- Reset: clk and rst only; synchronous, active-high. While rst=1 on an edge: out_valid=0, stage-1 valid=0, out_data=0, out_inv=0, all internal data registers=0. in_ready=1 in the cycle after reset.
- Row offsets: for NB=4 or NB=6, rows 0..3 use 0,1,2,3. For NB=8, rows 0..3 use 0,1,3,4.
- Forward: out(r,c) = in(r, (c+off[r]) mod NB).
- Inverse: out(r,c) = in(r, (c-off[r]+NB) mod NB).
- The permutation is pure wiring with no arithmetic on data.
- Two register stages:
  - S1 captures in_data/in_inv on the handshake.
  - S2 holds the permuted result.
  - Permutation is combinational between S1 and S2.
- Latency: 2 cycles from the in_valid&&in_ready edge to out_valid=1.
- Throughput: one state per cycle when out_ready stays high.
- Advance rule:
  - S2 loads when S1 is valid and (S2 empty or out_ready).
  - S1 loads when in_valid and in_ready.
  - in_ready = !S1valid || S2 loads this cycle. This is combinational from out_ready; no path from in_valid to in_ready.
- Stall: while out_valid && !out_ready, out_data and out_inv stay stable. Once S1 is also full, in_ready=0 and no data is lost or duplicated.
- Simultaneous events: when S2 drains, S1 moves to S2 and a new input enters S1 on the same edge.
- Mode mixing: each transfer carries its own in_inv, and back-to-back transfers may alternate modes. Each output is permuted per its own tag.
- Reset mid-operation: all in-flight states are discarded, with no output for them.
- in_valid may drop without a transfer; the stage holds no input state in that case.

Optional Feature:
Macro SHIFT_ROWS_PARITY_EN.
- When defined: adds an output port out_par [SENTENCE/8-1:0]. It is the per-byte even parity of out_data, registered in S2 alongside the data, reset to 0, and stable under stall.
- When undefined: the port is absent; all other behaviour is identical.

Decomposition:
- Shared package aes_pkg:
  - BYTE constant
  - legal-NB check
  - function row_offset(nb, r)
  - function src_col(nb, r, c, inv)
- Sub-module shift_rows_perm (combinational): parameters BYTE and NB; inputs state and inv; output permuted state. It is instantiated between S1 and S2.

Test Plan:
- NB=4, forward, input d42711aee0bf98f1b8b45de51e415230 (FIPS-197 round 1) -> out_data d4bf5d30e0b452aeb84111f11e2798e5, out_inv=0, out_valid exactly 2 cycles after the handshake.
- NB=4, alternate in_inv every cycle, inputs 000102030405060708090a0b0c0d0e0f and its forward image 00050a0f04090e03080d02070c01060b:
  - forward -> 00050a0f04090e03080d02070c01060b
  - inverse of the image -> 000102...0f
  - one result per cycle, in order.
- NB=8, forward, input bytes 0x00..0x1f -> column 0 = 00 05 0e 13, column 7 = 1c 01 0a 0f. Inverse of that output returns 00..1f.
- Backpressure: hold out_ready=0 for 5 cycles with a continuous input stream:
  - out_data constant
  - in_ready=0 after 2 accepts
  - on release, every accepted state emerges once, in order.
- Reset mid-stream: assert rst with S1 and S2 full -> next cycle out_valid=0, out_data=0, in_ready=1. No stale output after reset deasserts.
- SHIFT_ROWS_PARITY_EN, input all 0x01 bytes -> out_par all ones. All 0x03 bytes -> out_par all zeros.
